mux_scan_ctrl: RTL and testbench

//  Upstream controller for the 4:1 mux (inputs A/B/C/D, selects S1/S2, output O).

---
 rtl/mux_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scanner that drives the selects of a 4:1 mux,
// waits a settle time, samples its output and gathers a per-channel frame.
// Ports:
//   clk, rst (sync, active-high), en, req[3:0], mux_o
//   S1, S2 (registered selects), smp_valid, smp_bit, smp_ch[1:0],
//   frame[3:0], frame_valid
module mux_scan_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       mux_o,
   output logic       S1,
   output logic       S2,
   output logic       smp_valid,
   output logic       smp_bit,
   output logic [1:0] smp_ch,
   output logic [3:0] frame,
   output logic       frame_valid
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       last_ch;
   logic [1:0]       cur_ch;
   logic [1:0]       base;
   logic [1:0]       pick;
   logic             load;
   logic             take;
   logic             wrap;

   assign cur_ch = {S2, S1};

   // In SAMPLE the channel being sampled becomes last_ch on this edge,
   // so the search has to start after it rather than after the stale value.
   assign base = (state == SAMPLE) ? cur_ch : last_ch;

   // First requested channel after base; scanning k from far to near
   // lets the nearest hit win.
   always_comb begin
      pick = base;
      for (int k = 4; k >= 1; k--) begin
         if (req[base + 2'(k)]) pick = base + 2'(k);
      end
   end

   // Sweep ends when no higher-indexed channel is still requested.
   assign wrap = ((req >> cur_ch) & 4'b1110) == 4'b0000;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = load ? SETTLE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      load = 1'b0;
      take = 1'b0;
      case (state)
         IDLE:    load = en && (|req);
         SAMPLE: begin
            take = 1'b1;
            load = en && (|req);
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         S1          <= 1'b0;
         S2          <= 1'b0;
         cnt         <= '0;
         last_ch     <= 2'd3;
         smp_valid   <= 1'b0;
         smp_bit     <= 1'b0;
         smp_ch      <= 2'd0;
         frame       <= 4'b0000;
         frame_valid <= 1'b0;
      end else begin
         smp_valid   <= take;
         frame_valid <= take && wrap;
         if (take) begin
            smp_bit       <= mux_o;
            smp_ch        <= cur_ch;
            frame[cur_ch] <= mux_o;
            last_ch       <= cur_ch;
         end
         if (load) begin
            {S2, S1} <= pick;
            cnt      <= CNT_W'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: randomized and directed checks of mux_scan_ctrl
// against a transaction-timed reference model with a modelled 4:1 mux.
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] mux_in = 4'b0000;

   logic       a_s1, a_s2, a_sv, a_bit, a_fv;
   logic [1:0] a_ch;
   logic [3:0] a_fr;
   logic       b_s1, b_s2, b_sv, b_bit, b_fv;
   logic [1:0] b_ch;
   logic [3:0] b_fr;
   logic       a_mo, b_mo;
   logic [10:0] got_a, got_b;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   assign a_mo = mux_in[{a_s2, a_s1}];
   assign b_mo = mux_in[{b_s2, b_s1}];

   assign got_a = {a_s2, a_s1, a_sv, a_fv, a_fr,
                   a_sv ? {a_bit, a_ch} : 3'b000};
   assign got_b = {b_s2, b_s1, b_sv, b_fv, b_fr,
                   b_sv ? {b_bit, b_ch} : 3'b000};

   mux_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .mux_o(a_mo),
      .S1(a_s1), .S2(a_s2), .smp_valid(a_sv), .smp_bit(a_bit),
      .smp_ch(a_ch), .frame(a_fr), .frame_valid(a_fv)
   );

   mux_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .en(en), .req(req), .mux_o(b_mo),
      .S1(b_s1), .S2(b_s2), .smp_valid(b_sv), .smp_bit(b_bit),
      .smp_ch(b_ch), .frame(b_fr), .frame_valid(b_fv)
   );

   // Reference model: tracks which channel is selected and the absolute
   // cycle at which it will be sampled.
   int         cyc = 0;
   int         settle = 2;
   int         samp_at = 0;
   bit         busy = 0;
   logic [1:0] m_sel = 2'd0;
   logic [1:0] m_last = 2'd3;
   logic [1:0] m_ch = 2'd0;
   logic       m_bit = 1'b0;
   logic       m_sv = 1'b0;
   logic       m_fv = 1'b0;
   logic [3:0] m_fr = 4'b0000;
   logic [10:0] m_vec = '0;

   function automatic logic [1:0] next_ch(input logic [1:0] last,
                                          input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (int'(last) + k) % 4;
         if (r[i]) return 2'(i);
      end
      return last;
   endfunction

   task automatic model_edge();
      m_sv = 1'b0;
      m_fv = 1'b0;
      if (rst) begin
         busy = 0;
         m_sel = 2'd0;
         m_last = 2'd3;
         m_ch = 2'd0;
         m_bit = 1'b0;
         m_fr = 4'b0000;
      end else if (!busy) begin
         if (en && req != 4'b0000) begin
            m_sel = next_ch(m_last, req);
            busy = 1;
            samp_at = cyc + settle + 1;
         end
      end else if (cyc == samp_at) begin
         m_sv = 1'b1;
         m_bit = mux_in[m_sel];
         m_ch = m_sel;
         m_fr[m_sel] = m_bit;
         m_fv = (int'(req) >> (int'(m_sel) + 1)) == 0;
         m_last = m_sel;
         if (en && req != 4'b0000) begin
            m_sel = next_ch(m_last, req);
            samp_at = cyc + settle + 1;
         end else begin
            busy = 0;
         end
      end
      cyc++;
      m_vec = {m_sel, m_sv, m_fv, m_fr, m_sv ? {m_bit, m_ch} : 3'b000};
   endtask

   task automatic cyc_step(input logic r, input logic e,
                           input logic [3:0] q, input logic [3:0] mi);
      @(negedge clk);
      rst = r;
      en = e;
      req = q;
      mux_in = mi;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      settle = 2;
      cyc_step(1'b1, 1'b1, 4'b1111, 4'b1111);
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b0000);
      vecs++;
      if (got_a !== 11'b0) begin
         errs++;
         $display("FAIL reset got %h exp %h", got_a, 11'b0);
      end
      vecs++;
      if (got_a !== m_vec) begin
         errs++;
         $display("FAIL reset_model got %h exp %h", got_a, m_vec);
      end
   endtask

   task automatic test_all_channels();
      settle = 2;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b1101);
      for (int i = 0; i < 16; i++) begin
         cyc_step(1'b0, 1'b1, 4'b1111, 4'b1101);
         vecs++;
         if (got_a !== m_vec) begin
            errs++;
            $display("FAIL all_ch cyc %0d got %h exp %h", i, got_a, m_vec);
         end
      end
      vecs++;
      if (a_fr !== 4'b1101) begin
         errs++;
         $display("FAIL all_ch_frame got %b exp %b", a_fr, 4'b1101);
      end
   endtask

   task automatic test_alternate();
      settle = 2;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b1111);
      for (int i = 0; i < 14; i++) begin
         cyc_step(1'b0, 1'b1, 4'b0101, 4'b1111);
         vecs++;
         if (got_a !== m_vec) begin
            errs++;
            $display("FAIL alt cyc %0d got %h exp %h", i, got_a, m_vec);
         end
      end
      vecs++;
      if ((a_fr & 4'b1010) !== 4'b0000) begin
         errs++;
         $display("FAIL alt_unreq got %b exp %b", a_fr, 4'b0101);
      end
   endtask

   task automatic test_latency();
      settle = 2;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b0010);
      cyc_step(1'b0, 1'b1, 4'b0000, 4'b0010);
      cyc_step(1'b0, 1'b1, 4'b0010, 4'b0010);
      vecs++;
      if ({a_s2, a_s1} !== 2'b01) begin
         errs++;
         $display("FAIL lat_sel got %b exp 01", {a_s2, a_s1});
      end
      for (int i = 1; i <= 3; i++) begin
         cyc_step(1'b0, 1'b0, 4'b0000, 4'b0010);
         vecs++;
         if (a_sv !== (i == 3)) begin
            errs++;
            $display("FAIL lat_valid +%0d got %b exp %b", i, a_sv, i == 3);
         end
      end
      vecs++;
      if (a_ch !== 2'd1 || a_bit !== 1'b1) begin
         errs++;
         $display("FAIL lat_ch got %0d/%b exp 1/1", a_ch, a_bit);
      end
   endtask

   task automatic test_en_drop(input bit drop_req);
      int pulses;
      settle = 2;
      pulses = 0;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b0000);
      cyc_step(1'b0, 1'b1, 4'b0010, 4'b0000);
      for (int i = 0; i < 7; i++) begin
         cyc_step(1'b0, drop_req, drop_req ? 4'b0000 : 4'b0010, 4'b0000);
         if (a_sv) pulses++;
         vecs++;
         if (got_a !== m_vec) begin
            errs++;
            $display("FAIL drop%0d cyc %0d got %h exp %h",
                     drop_req, i, got_a, m_vec);
         end
      end
      vecs++;
      if (pulses != 1 || {a_s2, a_s1} !== 2'b01) begin
         errs++;
         $display("FAIL drop%0d_end got %0d/%b exp 1/01",
                  drop_req, pulses, {a_s2, a_s1});
      end
   endtask

   task automatic test_rst_mid();
      settle = 2;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b1010);
      cyc_step(1'b0, 1'b1, 4'b1111, 4'b1010);
      cyc_step(1'b0, 1'b1, 4'b1111, 4'b1010);
      cyc_step(1'b1, 1'b1, 4'b1111, 4'b1010);
      vecs++;
      if (got_a !== 11'b0) begin
         errs++;
         $display("FAIL rst_mid got %h exp %h", got_a, 11'b0);
      end
      for (int i = 0; i < 5; i++) begin
         cyc_step(1'b0, 1'b1, 4'b1000, 4'b1010);
         vecs++;
         if (got_a !== m_vec) begin
            errs++;
            $display("FAIL rst_re cyc %0d got %h exp %h", i, got_a, m_vec);
         end
      end
      vecs++;
      if (a_ch !== 2'd3 || a_fr !== 4'b1000) begin
         errs++;
         $display("FAIL rst_ch3 got %0d/%b exp 3/1000", a_ch, a_fr);
      end
   endtask

   task automatic test_random();
      settle = 2;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < 400; i++) begin
         cyc_step(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 5) != 0),
                  4'($urandom), 4'($urandom));
         vecs++;
         if (got_a !== m_vec) begin
            errs++;
            $display("FAIL rand cyc %0d got %h exp %h", i, got_a, m_vec);
         end
      end
   endtask

   task automatic test_settle1();
      int pulses;
      settle = 1;
      pulses = 0;
      cyc_step(1'b1, 1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         cyc_step(1'b0, 1'b1, 4'b1111, 4'($urandom));
         if (b_sv) pulses++;
         vecs++;
         if (got_b !== m_vec) begin
            errs++;
            $display("FAIL s1 cyc %0d got %h exp %h", i, got_b, m_vec);
         end
      end
      vecs++;
      if (pulses != 5) begin
         errs++;
         $display("FAIL s1_rate got %0d exp 5", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_all_channels();
      test_alternate();
      test_latency();
      test_en_drop(1'b0);
      test_en_drop(1'b1);
      test_rst_mid();
      test_random();
      test_settle1();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
